// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with a per-register busy
// scoreboard for decode-stage hazard detection and a sequential clear engine.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 19,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              Regreset_n,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              busy1,
  output logic              busy2
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   clr_idx_reg;
  logic                clr_busy_reg;
  logic [DATA_W-1:0]   mem_reg [DEPTH];
  logic [DEPTH-1:0]    busy_reg;

  logic idle;
  logic wr_ok;
  logic iss_ok;
  logic clr_start;
  logic clr_last;

  assign idle      = (state_reg == ST_IDLE);
  // Register 0 is hardwired when ZERO_REG is set, so it never accepts data or a tag.
  assign wr_ok     = WE3 && idle && !((ZERO_REG != 0) && (A3 == '0));
  assign iss_ok    = iss_valid && idle && !((ZERO_REG != 0) && (iss_rd == '0));
  assign clr_start = idle && clr_req;
  assign clr_last  = (clr_idx_reg == ADDR_W'(DEPTH - 1));

  // Clear engine: walks the index over every entry once, then returns to idle.
  always_ff @(posedge clock or negedge Regreset_n) begin
    if (!Regreset_n) begin
      state_reg    <= ST_IDLE;
      clr_idx_reg  <= '0;
      clr_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clr_req) begin
            state_reg    <= ST_CLEAR;
            clr_idx_reg  <= '0;
            clr_busy_reg <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_idx_reg <= clr_idx_reg + 1'b1;
          if (clr_last) begin
            state_reg    <= ST_IDLE;
            clr_busy_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          clr_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Data entry: the clear engine has priority; writeback writes are only accepted while idle.
      always_ff @(posedge clock or negedge Regreset_n) begin
        if (!Regreset_n) begin
          mem_reg[gi] <= '0;
        end else if (!idle && (clr_idx_reg == ADDR_W'(gi))) begin
          mem_reg[gi] <= '0;
        end else if (wr_ok && (A3 == ADDR_W'(gi))) begin
          mem_reg[gi] <= WD3;
        end
      end

      // Busy bit: starting a clear wipes the scoreboard; a new issue beats a same-cycle retire.
      always_ff @(posedge clock or negedge Regreset_n) begin
        if (!Regreset_n) begin
          busy_reg[gi] <= 1'b0;
        end else if (clr_start) begin
          busy_reg[gi] <= 1'b0;
        end else if (iss_ok && (iss_rd == ADDR_W'(gi))) begin
          busy_reg[gi] <= 1'b1;
        end else if (wr_ok && (A3 == ADDR_W'(gi))) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Read port 1: array lookup, optional same-cycle bypass, zero-register override last.
  always_comb begin
    RD1   = mem_reg[A1];
    busy1 = busy_reg[A1];
`ifdef REGFILE_BYPASS_EN
    if (WE3 && idle && (A3 == A1)) begin
      RD1   = WD3;
      busy1 = 1'b0;
    end
`endif
    if ((ZERO_REG != 0) && (A1 == '0)) begin
      RD1   = '0;
      busy1 = 1'b0;
    end
  end

  // Read port 2: identical structure to port 1.
  always_comb begin
    RD2   = mem_reg[A2];
    busy2 = busy_reg[A2];
`ifdef REGFILE_BYPASS_EN
    if (WE3 && idle && (A3 == A2)) begin
      RD2   = WD3;
      busy2 = 1'b0;
    end
`endif
    if ((ZERO_REG != 0) && (A2 == '0)) begin
      RD2   = '0;
      busy2 = 1'b0;
    end
  end

endmodule
